// File: rtl/capture_fill_if.sv
// RAM write port of the capture engine: one registered write strobe with its address and data.
interface capture_fill_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/capture_fill.sv
// Oscilloscope-style capture engine: optional rising-edge trigger, decimation, and one frame of
// DEPTH samples written to display RAM, then held in DONE until the display acknowledges.
module capture_fill #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 160,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_adc,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic              done_ack,
  input  logic              cont,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [3:0]        decim,
  input  logic [DATA_W-1:0] adc_data,
  capture_fill_if.master    wr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StArmed, StFill, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        dec_q, dec_d, dec_next;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              first_q, first_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      dec_q     <= '0;
      prev_q    <= '0;
      first_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dec_q     <= dec_d;
      prev_q    <= prev_d;
      first_q   <= first_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // >= rather than == so a decim reduced mid-count still wraps on the next sample
  assign dec_next = (dec_q >= decim) ? 4'd0 : dec_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dec_d     = dec_q;
    prev_d    = prev_q;
    first_d   = first_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (trig_en) begin
            state_d = StArmed;
            first_d = 1'b1;
          end else begin
            state_d = StFill;
            addr_d  = '0;
            dec_d   = '0;
          end
        end
      end

      StArmed: begin
        if (enable) begin
          prev_d  = adc_data;
          first_d = 1'b0;
          // first_q suppresses a false edge against a stale prev
          if (!first_q && (prev_q < trig_level) && (adc_data >= trig_level)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = adc_data;
            dec_d     = (decim == 4'd0) ? 4'd0 : 4'd1;
            if (LastAddr == '0) begin
              state_d = StDone;
            end else begin
              state_d = StFill;
              addr_d  = ADDR_W'(1);
            end
          end
        end
      end

      StFill: begin
        if (enable) begin
          dec_d = dec_next;
          if (dec_q == 4'd0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = adc_data;
            if (addr_q == LastAddr) begin
              state_d = StDone;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
      end

      StDone: begin
        if (done_ack) begin
          if (!cont) begin
            state_d = StIdle;
          end else if (trig_en) begin
            state_d = StArmed;
            first_d = 1'b1;
          end else begin
            state_d = StFill;
            addr_d  = '0;
            dec_d   = '0;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign busy       = (state_q == StArmed) || (state_q == StFill);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_capture_fill.sv
// Directed bench for capture_fill: free-run fill, trigger, decimation, gated enable, reset, re-arm.
module tb_capture_fill;

  logic       clk_adc = 1'b0;
  logic       reset_n;
  logic       enable, start, done_ack, cont, trig_en;
  logic [7:0] trig_level, adc_data;
  logic [3:0] decim;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  capture_fill_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  capture_fill #(.DATA_W(8), .DEPTH(160), .ADDR_W(8)) dut (
    .clk_adc    (clk_adc),
    .reset_n    (reset_n),
    .enable     (enable),
    .start      (start),
    .done_ack   (done_ack),
    .cont       (cont),
    .trig_en    (trig_en),
    .trig_level (trig_level),
    .decim      (decim),
    .adc_data   (adc_data),
    .wr         (bus.master),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_adc = ~clk_adc;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"},  32'(bus.wr_en),   32'd0);
    check({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
    check({tag, "_data"}, 32'(bus.wr_data), 32'd0);
    check({tag, "_busy"}, 32'(busy),        32'd0);
    check({tag, "_done"}, 32'(done),        32'd0);
  endtask

  logic [7:0] trig_seq [6];
  logic       trig_wen [6];
  int         nw, first_k, last_k;
  logic       hit;

  initial begin
    trig_seq = '{8'h90, 8'h90, 8'h70, 8'h7F, 8'h80, 8'h81};
    trig_wen = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset_n = 1'b0; enable = 1'b0; start = 1'b0; done_ack = 1'b0; cont = 1'b0;
    trig_en = 1'b0; trig_level = 8'h00; decim = 4'd0; adc_data = 8'h00;
    #2;
    check_all_zero("reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Free-running ramp fill
    enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ramp_busy", 32'(busy), 32'd1);
    adc_data = 8'd0;
    for (int i = 0; i < 160; i++) begin
      tick();
      check("ramp_wen",  32'(bus.wr_en),   32'd1);
      check("ramp_addr", 32'(bus.wr_addr), 32'(i));
      check("ramp_data", 32'(bus.wr_data), 32'(i));
      check("ramp_done", 32'(done),        32'(i == 159));
      adc_data = 8'(i + 1);
    end
    tick();
    check("ramp_post_wen",  32'(bus.wr_en), 32'd0);
    check("ramp_post_busy", 32'(busy),      32'd0);
    check("ramp_post_done", 32'(done),      32'd1);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check("ack_idle_done", 32'(done), 32'd0);
    check("ack_idle_busy", 32'(busy), 32'd0);

    // Rising-edge trigger at 0x80
    trig_en = 1'b1; trig_level = 8'h80; start = 1'b1;
    tick();
    start = 1'b0;
    check("arm_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      adc_data = trig_seq[i];
      tick();
      check("trig_wen", 32'(bus.wr_en), 32'(trig_wen[i]));
      if (trig_wen[i]) begin
        check("trig_addr", 32'(bus.wr_addr), 32'(i - 4));
        check("trig_data", 32'(bus.wr_data), 32'(trig_seq[i]));
      end
    end
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_trig");
    tick();
    reset_n = 1'b1;
    trig_en = 1'b0;

    // Decimation by 3
    decim = 4'd2; start = 1'b1; adc_data = 8'd0;
    tick();
    start = 1'b0;
    nw = 0; first_k = -1; last_k = -1;
    for (int k = 0; k < 600 && nw < 160; k++) begin
      adc_data = 8'(k);
      tick();
      if (bus.wr_en) begin
        check("dec_addr", 32'(bus.wr_addr), 32'(nw));
        check("dec_data", 32'(bus.wr_data), 32'((3 * nw) & 255));
        if (nw == 0) first_k = k;
        last_k = k;
        nw++;
      end
    end
    check("dec_count", 32'(nw), 32'd160);
    check("dec_first", 32'(first_k), 32'd0);
    check("dec_span",  32'(last_k - first_k), 32'd477);
    check("dec_done",  32'(done), 32'd1);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    check("dec_ack_done", 32'(done), 32'd0);

    // Gated enable, no decimation
    decim = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      enable = (k % 2 == 0);
      adc_data = 8'(8'hA0 + k);
      tick();
      check("tog_wen", 32'(bus.wr_en), 32'(k % 2 == 0));
      if (k % 2 == 0) begin
        check("tog_addr", 32'(bus.wr_addr), 32'(k / 2));
        check("tog_data", 32'(bus.wr_data), 32'(8'hA0 + k));
      end
    end

    // Reset straight after the address-50 write
    enable = 1'b1; hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      adc_data = 8'(k);
      tick();
      if (bus.wr_en && bus.wr_addr == 8'd50) hit = 1'b1;
    end
    check("a50_seen", 32'(hit), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_a50");
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("norestart_wen",  32'(bus.wr_en), 32'd0);
      check("norestart_busy", 32'(busy),      32'd0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", 32'(busy),      32'd1);
    check("restart_wen0", 32'(bus.wr_en), 32'd0);
    adc_data = 8'h33;
    tick();
    check("restart_wen",  32'(bus.wr_en),   32'd1);
    check("restart_addr", 32'(bus.wr_addr), 32'd0);
    check("restart_data", 32'(bus.wr_data), 32'h33);

    // Continuous mode: done_ack wins over start, next frame starts at address 0
    cont = 1'b1; hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      adc_data = 8'(k);
      tick();
      if (done) hit = 1'b1;
    end
    check("cont_done",      32'(hit),          32'd1);
    check("cont_last_addr", 32'(bus.wr_addr),  32'd159);
    tick();
    check("cont_hold_done", 32'(done),      32'd1);
    check("cont_hold_wen",  32'(bus.wr_en), 32'd0);
    check("cont_hold_busy", 32'(busy),      32'd0);
    done_ack = 1'b1; start = 1'b1;
    tick();
    done_ack = 1'b0; start = 1'b0;
    check("cont_rearm_done", 32'(done),      32'd0);
    check("cont_rearm_busy", 32'(busy),      32'd1);
    check("cont_rearm_wen",  32'(bus.wr_en), 32'd0);
    adc_data = 8'h5A;
    tick();
    check("cont_first_wen",  32'(bus.wr_en),   32'd1);
    check("cont_first_addr", 32'(bus.wr_addr), 32'd0);
    check("cont_first_data", 32'(bus.wr_data), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
